// File: rtl/priarb_8ch_pkg.sv
// Shared types and constants for the eight-channel priority arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package priarb_8ch_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Binary index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [IDX_W-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage

// File: rtl/priarb_8ch_prisel.sv
// Masked priority selector: fixed (highest index wins) or rotating search below start.
// Latency: purely combinational.
// Backpressure: none; found is low when the vector is empty.
module prisel_8
  import priarb_8ch_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  input  logic               rr_mode,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] cand;

  // Search base-1, base-2, ... wrapping, base last. Fixed mode is the same
  // search from base 0, which visits 7 first and reduces to highest-index-wins.
  // The loop runs from the farthest position inward so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    base  = rr_mode ? start : '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = base - IDX_W'(k);
      if (vec[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priarb_8ch.sv
// Eight-channel arbiter: registered one-hot grant held until release or hold limit.
// Latency: request or release in cycle N changes the grant in cycle N+1.
// Backpressure: a holder keeps the grant at most MAX_HOLD cycles while others wait.
module priarb_8ch
  import priarb_8ch_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               rr_mode,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  state_t             state, state_nxt;
  logic [7:0]         hold_cnt, hold_nxt;
  logic [IDX_W-1:0]   last_idx, last_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic               holder_req;
  logic               timeout;

  // While granted, gnt is the holder's one-hot, so masking with it removes the
  // holder from the candidate set for both release and timeout arbitration.
  assign cand       = (state == GRANT) ? (req & ~gnt) : req;
  assign holder_req = req[gnt_idx];
  assign timeout    = (hold_cnt == 8'(MAX_HOLD - 1));
  assign gnt_valid  = (state == GRANT);

  prisel_8 u_sel (
    .vec     (cand),
    .start   (last_idx),
    .rr_mode (rr_mode),
    .idx     (win_idx),
    .found   (win_found)
  );

  // Next-state, next grant index, hold counter and rotation pointer.
  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    hold_nxt  = hold_cnt;
    last_nxt  = last_idx;
    case (state)
      IDLE: begin
        if (enable && win_found) begin
          state_nxt = GRANT;
          idx_nxt   = win_idx;
          last_nxt  = win_idx;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (!enable) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          hold_nxt  = '0;
        end else if (!holder_req) begin
          hold_nxt = '0;
          if (win_found) begin
            idx_nxt  = win_idx;
            last_nxt = win_idx;
          end else begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end
        end else if (timeout) begin
          // No other requester: the holder is simply regranted for a fresh period.
          hold_nxt = '0;
          if (win_found) begin
            idx_nxt  = win_idx;
            last_nxt = win_idx;
          end
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
      last_idx <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= (state_nxt == GRANT) ? idx2oh(idx_nxt) : '0;
      gnt_idx  <= idx_nxt;
      hold_cnt <= hold_nxt;
      last_idx <= last_nxt;
    end
  end

endmodule

// File: tb/tb_priarb_8ch.sv
// Directed-vector and invariant bench for priarb_8ch.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: n/a.
module tb_priarb_8ch;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rr_mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int checks   = 0;
  int failures = 0;

  priarb_8ch #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rr_mode   (rr_mode),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       rr;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    string      name;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] eg, input logic [2:0] ei,
                           input logic ev);
    check({name, ".gnt"}, {24'd0, gnt}, {24'd0, eg});
    check({name, ".idx"}, {29'd0, gnt_idx}, {29'd0, ei});
    check({name, ".vld"}, {31'd0, gnt_valid}, {31'd0, ev});
  endtask

  int         streak;
  logic       cond;
  logic [7:0] pre_gnt;
  logic [2:0] exp_i;

  initial begin
    //          rst   en    rr    req         gnt         idx   vld
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'hFF,      8'h00,      3'd0, 1'b0, "reset_a"};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'hFF,      8'h00,      3'd0, 1'b0, "reset_b"};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'hFF,      8'h80,      3'd7, 1'b1, "post_reset"};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'b00100110, 8'h20,     3'd5, 1'b1, "fixed_5"};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'b00000110, 8'h04,     3'd2, 1'b1, "fixed_2_nobubble"};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'b00000110, 8'h00,     3'd0, 1'b0, "disable"};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h10,      8'h10,      3'd4, 1'b1, "grant_4"};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h10,      8'h00,      3'd0, 1'b0, "disable_mid"};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'hFF,      8'h08,      3'd3, 1'b1, "rr_from_3"};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'hFF,      8'h00,      3'd0, 1'b0, "reset_mid"};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00,      8'h00,      3'd0, 1'b0, "idle_noreq"};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h01,      8'h01,      3'd0, 1'b1, "grant_0"};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h03,      8'h01,      3'd0, 1'b1, "nonholder_ignored"};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h02,      8'h02,      3'd1, 1'b1, "release_to_1"};

    rst_n = 1'b0; enable = 1'b0; rr_mode = 1'b0; req = 8'h00;
    #1;

    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n; enable = tbl[i].en; rr_mode = tbl[i].rr; req = tbl[i].req;
      tick();
      check_out(tbl[i].name, tbl[i].gnt, tbl[i].idx, tbl[i].vld);
    end

    // Round-robin rotation: each grantee drops its request for one cycle.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; enable = 1'b1; rr_mode = 1'b1; req = 8'hFF;
    tick();
    check_out("rr_first", 8'h80, 3'd7, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      req = 8'hFF & ~gnt;
      tick();
      exp_i = 3'(7 - k);
      check_out($sformatf("rr_step%0d", k), 8'h01 << exp_i, exp_i, 1'b1);
    end

    // Hold limit with two steady requesters, fixed mode.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; enable = 1'b1; rr_mode = 1'b0; req = 8'b1000_0001;
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      tick();
      exp_i = (c >= MAX_HOLD && c < 2 * MAX_HOLD) ? 3'd0 : 3'd7;
      check_out($sformatf("timeout_c%0d", c), 8'h01 << exp_i, exp_i, 1'b1);
    end
    // Lone holder is regranted without ever dropping valid.
    req = 8'h80;
    for (int c = 0; c < 2 * MAX_HOLD + 5; c++) begin
      tick();
      check_out($sformatf("regrant_c%0d", c), 8'h80, 3'd7, 1'b1);
    end

    // Random run with invariant checks.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    streak = 0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(31) == 0) req = 8'($urandom);
      enable = ($urandom_range(63) != 0);
      if ($urandom_range(127) == 0) rr_mode = ~rr_mode;
      rst_n = ($urandom_range(999) != 0);
      cond = gnt_valid && enable && rst_n && req[gnt_idx] && (|(req & ~gnt));
      pre_gnt = gnt;
      tick();
      check("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      check("gnt_at_idx", {31'd0, gnt[gnt_idx]}, {31'd0, gnt_valid});
      if (cond && gnt == pre_gnt) streak++;
      else streak = 0;
      if (cond) check("hold_limit", {31'd0, streak >= MAX_HOLD}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priarb_8ch.md
# priarb_8ch

Eight-channel request arbiter built around the 8-to-3 priority-encoding function: it samples an 8-bit request vector, selects one winner, and holds a registered grant (one-hot and 3-bit index) until the winner releases or a hold limit expires. It sequences shared-resource access for up to eight requesters. Fixed-priority mode matches the encoder convention (bit 7 highest). Round-robin mode rotates priority downward from the last winner.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles one grant may be held (legal 2..255).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  arbitration enable; low forces grant off.
- `rr_mode`  in  1  0 = fixed priority (index 7 highest), 1 = round-robin.
- `req`  in  8  request vector; bit i = requester i.
- `gnt`  out  8  one-hot grant, registered.
- `gnt_idx`  out  3  binary index of granted requester, registered.
- `gnt_valid`  out  1  high when `gnt` is nonzero.

## Operation
- States: IDLE (no grant), GRANT (one requester owns resource).
- Reset (rst_n low at edge): state IDLE, `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `hold_cnt`=0, `last_idx`=0. Reset overrides all other inputs, including mid-grant.
- Winner selection, combinational from `req` masked by candidate set:
  - Fixed: highest set index.
  - RR: first set bit searching `last_idx`-1, `last_idx`-2, … descending, wrapping 0→7, with `last_idx` searched last. After reset (`last_idx`=0), the search starts at 7, so the result equals fixed priority.
- IDLE:
  - If `enable` and `|req`: register the winner.
  - Go to GRANT, set `last_idx`=winner, `hold_cnt`=0.
- GRANT, evaluated each cycle:
  - `enable` low → IDLE and clear outputs. `last_idx` is retained.
  - `req[gnt_idx]` low (release):
    - Arbitrate among the remaining requests in the same cycle. A winner is granted directly (GRANT→GRANT, no bubble).
    - No other requester → IDLE.
  - `req[gnt_idx]` high and `hold_cnt`=MAX_HOLD-1 (timeout):
    - Arbitrate with the holder's bit masked. Another winner gets the grant.
    - No other requester → holder is regranted.
    - Either way `hold_cnt`=0 and `last_idx`=new grantee.
  - Otherwise: hold the grant and increment `hold_cnt`.
- `rr_mode` change takes effect at the next arbitration. An active grant is not disturbed.
- `gnt` is always one-hot or zero. `gnt_valid` = (state==GRANT).

## Timing
- Latency: `req` asserted in cycle N (IDLE, enabled) → `gnt` valid in cycle N+1.
- Release: `req[gnt_idx]` low in cycle N → new grant or zero in cycle N+1. The old grant never overlaps the new one.
- Max hold: a continuously requesting holder sees `gnt` for exactly MAX_HOLD cycles before re-arbitration.
- `enable` low in cycle N → outputs zero in cycle N+1.
- Requests appearing or dropping for non-holders during GRANT have no effect until the next arbitration.
- `hold_cnt` width: 8 bits, saturating logic not required, because MAX_HOLD≤255.

## Structure
- Shared package: state encoding (IDLE=1'b0, GRANT=1'b1), `NUM_REQ`=8, `IDX_W`=3.
- One sub-module, `prisel_8`:
  - Combinational masked priority selector.
  - Inputs: 8-bit vector, 3-bit start index, mode bit.
  - Outputs: index and found flag.
  - Fixed mode ignores the start index.
- Top holds the FSM, counter, `last_idx` and output registers.

## Test plan
- Reset: drive `req`=8'hFF and `enable`=1 with `rst_n` low for 2 cycles → all outputs 0. Release reset → `gnt`=8'h80, `gnt_idx`=7 one cycle later.
- Fixed priority: `rr_mode`=0, `req`=8'b0010_0110 → `gnt_idx`=5. Drop bit 5 → next cycle `gnt_idx`=2, no idle cycle between.
- Round-robin: `rr_mode`=1, `req`=8'hFF, each grantee releases after 1 cycle then re-requests → grant sequence 7,6,5,4,3,2,1,0,7.
- Timeout: MAX_HOLD=16, `req`=8'b1000_0001 held steady, fixed mode → index 7 granted for 16 cycles, index 0 granted for the next 16, then 7 again. With `req`=8'h80 only → index 7 regranted continuously and `gnt_valid` never drops.
- Enable/reset mid-grant: `enable` low during a grant of index 4 → outputs 0 next cycle. Re-enable in RR mode → search starts at 3. `rst_n` low mid-grant → outputs 0 next cycle.
- Invariant check throughout a random 10k-cycle run: `gnt` is one-hot or zero, `gnt`[`gnt_idx`]==`gnt_valid`, and no grant exceeds MAX_HOLD cycles while other requests are pending.
